sort_frame_ctrl: RTL and testbench
==================================

// Module: sort_frame_ctrl
// PURPOSE
//  Frame controller wrapped around the 4-deep insertion sorter (top-4 tracker, 5-bit signed).
//  Accepts a valid/ready sample stream and drives the sorter's x input and per-frame clear.
//  After FRAME_LEN accepted samples, captures the sorter's y1..y4 and serialises them
//  largest-first on a valid/ready output stream.
// PARAMETERS
//  W          5   sample width, two's complement; must match the sorter
//  FRAME_LEN  16  samples per frame, >=1; counter width is $clog2(FRAME_LEN+1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  in_data    in   W   input sample
//  in_valid   in   1   in_data valid
//  in_ready   out  1   sample accepted when in_valid&&in_ready
//  sort_x     out  W   to sorter x
//  sort_clr   out  1   to sorter; integration ties sorter rst = rst|sort_clr
//  sort_y1..4 in   W   from sorter y1..y4 (y1 largest)
//  out_data   out  W   result value
//  out_valid  out  1   out_data valid
//  out_ready  in   1   consumer accepts when out_valid&&out_ready
//  out_last   out  1   high with the 4th (smallest) result of a frame
// BEHAVIOUR
//  - MIN = {1'b1,{W-1{1'b0}}} (-16 for W=5). MIN is the sorter's bubble: strict > means it never displaces.
//  - sort_x = (in_valid&&in_ready) ? in_data : MIN (combinational). No other input-to-output comb paths.
//  - Input FSM: FILL -> WAIT -> SETTLE -> FILL. cnt counts accepted samples in FILL.
//    FILL: the accept of sample FRAME_LEN moves to WAIT; cnt returns to 0.
//    WAIT: in_ready=0. Goes to SETTLE when the output buffer is not busy (same-cycle check).
//    SETTLE: 1 cycle. in_ready=0, sort_clr=1 (state decode). sort_y1..4 now hold the final frame result.
//      At the closing edge: capture them into hold[0..3], set busy, and the sorter clears.
//  - Sorter latency: 1 cycle. A sample accepted at edge k is reflected in sort_y* after edge k.
//  - Output side: busy=1 drives out_valid=1 and out_data=hold[idx], idx 0..3, out_last=(idx==3).
//    Each handshake increments idx. A handshake with idx==3 clears busy and resets idx to 0.
//    out_data/out_last stay stable while out_valid&&!out_ready.
//    Earliest out_valid: the cycle after SETTLE. Best case 4 beats later busy drops.
//  - in_ready: without FRAME_OVERLAP_EN it is (state==FILL)&&!busy; with the macro, see CONFIGURATION.
//  - busy clearing and a WAIT->SETTLE check in the same cycle: SETTLE waits 1 cycle (busy is registered).
//  - A sample of value MIN still counts toward FRAME_LEN.
//  - Empty slots report MIN (e.g. FRAME_LEN<4).
//  - Reset (any state, including mid-frame or mid-drain): state=FILL, cnt=0, busy=0, idx=0.
//    out_valid=0, out_data=0, out_last=0, hold=0. in_ready=1 in the cycle after reset.
//    sort_clr=0. Partial frames and undrained results are discarded. The sorter is cleared by rst itself.
// CONFIGURATION
//  FRAME_OVERLAP_EN defined:
//    - in_ready=(state==FILL): the next frame fills while the previous frame drains.
//    - A frame that completes during a drain parks in WAIT; the sorter holds because sort_x=MIN.
//  FRAME_OVERLAP_EN undefined:
//    - in_ready=(state==FILL)&&!busy: no sample is accepted during a drain.
//    - WAIT then lasts 0 extra cycles, except in the same-cycle case above.
// TESTING  (W=5, FRAME_LEN=8 unless stated)
//  1 in 3,-7,12,0,15,-1,8,5 back-to-back, out_ready=1 -> out 15,12,8,5; out_last on 5;
//    sort_clr high exactly 1 cycle.
//  2 in 4,4,-16,-16,-16,-16,-16,-16 with in_valid gaps -> out 4,4,-16,-16; out_valid only after the 8th accept.
//  3 Case 1 with out_ready=0 for 5 cycles on the first beat -> out_data holds 15 and out_valid stays 1.
//    Then 12,8,5 follow.
//  4 rst during 2nd beat of a drain -> next cycle out_valid=0, in_ready=1.
//    New frame 1..8 -> out 8,7,6,5 (no stale values).
//  5 FRAME_OVERLAP_EN, out_ready=0, two frames sent -> 2nd frame accepted and parks in WAIT.
//    out_ready=1 -> 15,12,8,5 then 2nd-frame top-4.
//    Without the macro: in_ready=0 until the 1st drain ends.
//  6 FRAME_LEN=2, in 7,-3 -> out 7,-3,-16,-16.

Source files
------------

// File: rtl/sort_frame_ctrl.sv
// rtl/sort_frame_ctrl.sv - frame controller around a 4-deep top-4 insertion sorter (option: FRAME_OVERLAP_EN)
module sort_frame_ctrl #(
  parameter int W         = 5,
  parameter int FRAME_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] sort_x,
  output logic         sort_clr,
  input  logic [W-1:0] sort_y1,
  input  logic [W-1:0] sort_y2,
  input  logic [W-1:0] sort_y3,
  input  logic [W-1:0] sort_y4,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  // Most negative value: the sorter's compare is strict, so this never displaces an entry
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [1:0]    r_idx;
  logic [W-1:0]  r_hold [4];

  logic          w_fill;
  logic          w_accept;

  assign w_fill = (r_state == ST_FILL);

`ifdef FRAME_OVERLAP_EN
  // Next frame may fill while the previous result is still draining
  assign in_ready = w_fill;
`else
  assign in_ready = w_fill && !r_busy;
`endif

  assign w_accept  = in_valid && in_ready;

  // Idle cycles feed the bubble value so the sorter contents are left untouched
  assign sort_x    = w_accept ? in_data : MIN;
  assign sort_clr  = (r_state == ST_SETTLE);

  assign out_valid = r_busy;
  assign out_data  = r_busy ? r_hold[r_idx] : '0;
  assign out_last  = r_busy && (r_idx == 2'd3);

  // Input FSM: count accepted samples, wait for a free result buffer, then one settle/clear cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            if (r_cnt == LAST_CNT) begin
              r_state <= ST_WAIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!r_busy) begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_state <= ST_FILL;
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  // Result buffer: capture sorter outputs on the settle edge, then serialise largest-first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= '0;
      end
    end else if (r_state == ST_SETTLE) begin
      r_hold[0] <= sort_y1;
      r_hold[1] <= sort_y2;
      r_hold[2] <= sort_y3;
      r_hold[3] <= sort_y4;
      r_busy    <= 1'b1;
      r_idx     <= 2'd0;
    end else if (r_busy && out_ready) begin
      if (r_idx == 2'd3) begin
        r_busy <= 1'b0;
        r_idx  <= 2'd0;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// tb/tb_sort_frame_ctrl.sv - scoreboard bench for sort_frame_ctrl with behavioural top-4 sorters
module tb_sort_frame_ctrl;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [4:0]  a_sort_x;
  logic        a_sort_clr;
  logic [19:0] a_y;
  logic [4:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic        a_out_last;

  logic [4:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [4:0]  b_sort_x;
  logic        b_sort_clr;
  logic [19:0] b_y;
  logic [4:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_out_last;

  sort_frame_ctrl #(.W(W), .FRAME_LEN(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sort_x(a_sort_x), .sort_clr(a_sort_clr),
    .sort_y1(a_y[19:15]), .sort_y2(a_y[14:10]), .sort_y3(a_y[9:5]), .sort_y4(a_y[4:0]),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last)
  );

  sort_frame_ctrl #(.W(W), .FRAME_LEN(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sort_x(b_sort_x), .sort_clr(b_sort_clr),
    .sort_y1(b_y[19:15]), .sort_y2(b_y[14:10]), .sort_y3(b_y[9:5]), .sort_y4(b_y[4:0]),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
  );

  // top-4 insertion sorter model, strict >, y1 in the top slice
  function automatic logic [19:0] ins(input logic [19:0] y, input logic [4:0] x);
    logic signed [4:0] v [4];
    int p;
    for (int i = 0; i < 4; i++) v[i] = y[(3-i)*5 +: 5];
    p = 4;
    for (int i = 3; i >= 0; i--) if ($signed(x) > v[i]) p = i;
    for (int i = 3; i > 0; i--) if (i > p) v[i] = v[i-1];
    if (p < 4) v[p] = x;
    return {v[0], v[1], v[2], v[3]};
  endfunction

  always @(posedge clk) begin
    if (rst || a_sort_clr) a_y <= {4{5'b10000}};
    else                   a_y <= ins(a_y, a_sort_x);
    if (rst || b_sort_clr) b_y <= {4{5'b10000}};
    else                   b_y <= ins(b_y, b_sort_x);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // scoreboard entries: {last, data}
  logic [5:0] qa [$];
  logic [5:0] qb [$];

  task automatic push_a(input int d0, input int d1, input int d2, input int d3);
    qa.push_back({1'b0, 5'(d0)});
    qa.push_back({1'b0, 5'(d1)});
    qa.push_back({1'b0, 5'(d2)});
    qa.push_back({1'b1, 5'(d3)});
  endtask

  // monitors: pop and compare on every output handshake
  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        fail("a_unexpected_beat");
      end else begin
        e = qa.pop_front();
        chk("a_out_data", int'($signed(a_out_data)), int'($signed(e[4:0])));
        chk("a_out_last", int'(a_out_last), int'(e[5]));
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        fail("b_unexpected_beat");
      end else begin
        e = qb.pop_front();
        chk("b_out_data", int'($signed(b_out_data)), int'($signed(e[4:0])));
        chk("b_out_last", int'(b_out_last), int'(e[5]));
      end
    end
  end

  int clr_cnt = 0;
  always @(negedge clk) if (a_sort_clr) clr_cnt++;

  int frm [8];

  task automatic send_frame(input bit gaps, input bit chk_idle);
    bit acc;
    int n;
    for (int i = 0; i < 8; i++) begin
      a_in_data  = 5'(frm[i]);
      a_in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = a_in_ready;
        if (acc && chk_idle) chk("no_valid_before_accept", int'(a_out_valid), 0);
        @(posedge clk); #1;
        if (!acc) begin
          n++;
          if (n > 300) begin
            fail("accept");
            a_in_valid = 1'b0;
            return;
          end
        end
      end
      if (gaps && (i % 3) != 0) begin
        a_in_valid = 1'b0;
        repeat (i % 3) begin @(posedge clk); #1; end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_drain_a();
    int n = 0;
    while (qa.size() != 0 || a_out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        fail("drain_a");
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n, cnt;
    bit acc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_data",  int'(a_out_data), 0);
    chk("rst_out_last",  int'(a_out_last), 0);
    chk("rst_in_ready",  int'(a_in_ready), 1);
    chk("rst_sort_clr",  int'(a_sort_clr), 0);
    chk("rst_sort_x",    int'($signed(a_sort_x)), -16);

    // 1: back-to-back, consumer always ready
    a_out_ready = 1'b1;
    c0 = clr_cnt;
    frm = '{3, -7, 12, 0, 15, -1, 8, 5};
    push_a(15, 12, 8, 5);
    send_frame(1'b0, 1'b1);
    wait_drain_a();
    chk("sort_clr_cycles", clr_cnt - c0, 1);

    // 2: gapped input, MIN samples count toward the frame
    frm = '{4, 4, -16, -16, -16, -16, -16, -16};
    push_a(4, 4, -16, -16);
    send_frame(1'b1, 1'b1);
    wait_drain_a();

    // 3: back-pressure on the first beat
    a_out_ready = 1'b0;
    frm = '{3, -7, 12, 0, 15, -1, 8, 5};
    push_a(15, 12, 8, 5);
    send_frame(1'b0, 1'b1);
    n = 0;
    while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(a_out_valid), 1);
      chk("stall_data",  int'($signed(a_out_data)), 15);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    wait_drain_a();

    // 4: reset during the second beat of a drain
    push_a(15, 12, 8, 5);
    send_frame(1'b0, 1'b0);
    n = 0;
    while (qa.size() != 3 && n < 100) begin @(posedge clk); #1; n++; end
    if (qa.size() != 3) fail("first_beat");
    a_out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    chk("mid_rst_out_valid", int'(a_out_valid), 0);
    chk("mid_rst_in_ready",  int'(a_in_ready), 1);
    chk("mid_rst_out_data",  int'(a_out_data), 0);
    chk("mid_rst_sort_clr",  int'(a_sort_clr), 0);
    a_out_ready = 1'b1;
    frm = '{1, 2, 3, 4, 5, 6, 7, 8};
    push_a(8, 7, 6, 5);
    send_frame(1'b0, 1'b1);
    wait_drain_a();

    // 5: second frame arriving while the first is held back
    a_out_ready = 1'b0;
    frm = '{3, -7, 12, 0, 15, -1, 8, 5};
    push_a(15, 12, 8, 5);
    send_frame(1'b0, 1'b0);
`ifdef FRAME_OVERLAP_EN
    frm = '{-5, 2, 9, -8, 11, 1, -2, 6};
    push_a(11, 9, 6, 2);
    send_frame(1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("park_in_ready", int'(a_in_ready), 0);
    chk("park_out_valid", int'(a_out_valid), 1);
    chk("park_out_data", int'($signed(a_out_data)), 15);
    a_out_ready = 1'b1;
    wait_drain_a();
`else
    a_in_valid = 1'b1;
    a_in_data  = 5'd15;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_in_ready) cnt++;
      @(posedge clk); #1;
    end
    chk("blocked_in_ready_cycles", cnt, 0);
    chk("blocked_out_data", int'($signed(a_out_data)), 15);
    a_in_valid = 1'b0;
    frm = '{-5, 2, 9, -8, 11, 1, -2, 6};
    push_a(11, 9, 6, 2);
    a_out_ready = 1'b1;
    send_frame(1'b0, 1'b0);
    wait_drain_a();
`endif

    // 6: FRAME_LEN=2 leaves empty slots at MIN
    qb.push_back({1'b0, 5'd7});
    qb.push_back({1'b0, 5'b11101});
    qb.push_back({1'b0, 5'b10000});
    qb.push_back({1'b1, 5'b10000});
    for (int i = 0; i < 2; i++) begin
      b_in_data  = (i == 0) ? 5'd7 : 5'b11101;
      b_in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) fail("b_accept");
    end
    b_in_valid = 1'b0;
    n = 0;
    while ((qb.size() != 0 || b_out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) fail("drain_b");

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
